// File: rtl/wifi_mem_arbiter_if.sv
// Bus bundle between the WIFI address decoder / PHY stream engine and the
// sample-memory arbiter, including the single-port memory interface.
interface wifi_mem_arbiter_if #(
   parameter int ADDR_SLIC = 10,
   parameter int DATA_W    = 32
);
   logic                 ahb_req_wr;
   logic                 ahb_req_rd;
   logic [ADDR_SLIC-1:0] ahb_addr;
   logic [DATA_W-1:0]    ahb_wdata;
   logic [DATA_W-1:0]    ahb_rdata;
   logic                 ahb_ready;
   logic                 ahb_err;
   logic                 ahb_err_clr;

   logic                 phy_req;
   logic                 phy_we;
   logic [ADDR_SLIC-1:0] phy_addr;
   logic [DATA_W-1:0]    phy_wdata;
   logic                 phy_gnt;
   logic                 phy_rvalid;
   logic [DATA_W-1:0]    phy_rdata;

   logic                 mem_en;
   logic                 mem_we;
   logic [ADDR_SLIC-1:0] mem_addr;
   logic [DATA_W-1:0]    mem_wdata;
   logic [DATA_W-1:0]    mem_rdata;

   // Arbiter view
   modport slave (
      input  ahb_req_wr, ahb_req_rd, ahb_addr, ahb_wdata, ahb_err_clr,
      input  phy_req, phy_we, phy_addr, phy_wdata,
      input  mem_rdata,
      output ahb_rdata, ahb_ready, ahb_err,
      output phy_gnt, phy_rvalid, phy_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata
   );

   // Requester / memory view
   modport master (
      output ahb_req_wr, ahb_req_rd, ahb_addr, ahb_wdata, ahb_err_clr,
      output phy_req, phy_we, phy_addr, phy_wdata,
      output mem_rdata,
      input  ahb_rdata, ahb_ready, ahb_err,
      input  phy_gnt, phy_rvalid, phy_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/wifi_mem_arbiter.sv
// Single-port WIFI sample memory arbiter: PHY stream has default priority, AHB wait bounded.
// Optional macro WIFI_ARB_STATS_EN adds the ahb_stall_cnt[15:0] stall statistics output.
module wifi_mem_arbiter #(
   parameter int ADDR_SLIC  = 10,
   parameter int DATA_W     = 32,
   parameter int MEM_RD_LAT = 1,
   parameter int MAX_WAIT   = 4
) (
   input  logic               HCLK,
   input  logic               HRESETn,
   wifi_mem_arbiter_if.slave  bus
`ifdef WIFI_ARB_STATS_EN
   ,
   output logic [15:0]        ahb_stall_cnt
`endif
);

   localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

   typedef enum logic [1:0] {A_IDLE, A_PEND, A_RDWAIT} a_state_t;

   a_state_t             a_state;
   logic                 pend_we;
   logic [ADDR_SLIC-1:0] pend_addr;
   logic [DATA_W-1:0]    pend_wdata;
   logic [3:0]           wait_cnt;

   logic [MEM_RD_LAT-1:0] rd_vld_p;
   logic [MEM_RD_LAT-1:0] rd_ahb_p;

   logic ahb_strobe;
   logic ahb_gnt;
   logic phy_gnt_c;
   logic rd_issue;
   logic ret_vld;
   logic ret_ahb;

   assign ahb_strobe = bus.ahb_req_wr | bus.ahb_req_rd;
   assign ahb_gnt    = (a_state == A_PEND) && (!bus.phy_req || (wait_cnt == MAX_W));
   assign phy_gnt_c  = bus.phy_req && !ahb_gnt;
   assign rd_issue   = (ahb_gnt && !pend_we) || (phy_gnt_c && !bus.phy_we);

   assign bus.phy_gnt = phy_gnt_c;

   always_comb begin
      bus.mem_en    = ahb_gnt | phy_gnt_c;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      if (ahb_gnt) begin
         bus.mem_we    = pend_we;
         bus.mem_addr  = pend_addr;
         bus.mem_wdata = pend_wdata;
      end else if (phy_gnt_c) begin
         bus.mem_we    = bus.phy_we;
         bus.mem_addr  = bus.phy_addr;
         bus.mem_wdata = bus.phy_wdata;
      end
   end

   // Read tag pipeline: stage 0 is loaded at issue, the last stage lines up with mem_rdata
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         rd_vld_p <= '0;
         rd_ahb_p <= '0;
      end else begin
         rd_vld_p <= MEM_RD_LAT'({rd_vld_p, rd_issue});
         rd_ahb_p <= MEM_RD_LAT'({rd_ahb_p, ahb_gnt});
      end
   end

   assign ret_vld = rd_vld_p[MEM_RD_LAT-1];
   assign ret_ahb = rd_ahb_p[MEM_RD_LAT-1];

   assign bus.phy_rvalid = ret_vld && !ret_ahb;
   assign bus.phy_rdata  = bus.mem_rdata;

   // Pending address/data only matter while a_state says the slot is live
   always_ff @(posedge HCLK) begin
      if ((a_state == A_IDLE) && ahb_strobe) begin
         pend_addr  <= bus.ahb_addr;
         pend_wdata <= bus.ahb_wdata;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         a_state       <= A_IDLE;
         pend_we       <= 1'b0;
         wait_cnt      <= '0;
         bus.ahb_ready <= 1'b1;
         bus.ahb_rdata <= '0;
      end else begin
         case (a_state)
            A_IDLE: begin
               if (ahb_strobe) begin
                  pend_we       <= bus.ahb_req_wr;
                  a_state       <= A_PEND;
                  bus.ahb_ready <= 1'b0;
               end
            end
            A_PEND: begin
               if (ahb_gnt) begin
                  if (pend_we) begin
                     a_state       <= A_IDLE;
                     bus.ahb_ready <= 1'b1;
                  end else begin
                     a_state <= A_RDWAIT;
                  end
               end
            end
            A_RDWAIT: begin
               if (ret_vld && ret_ahb) begin
                  bus.ahb_rdata <= bus.mem_rdata;
                  bus.ahb_ready <= 1'b1;
                  a_state       <= A_IDLE;
               end
            end
            default: a_state <= A_IDLE;
         endcase

         if (ahb_gnt)
            wait_cnt <= '0;
         else if ((a_state == A_PEND) && (wait_cnt != MAX_W))
            wait_cnt <= wait_cnt + 4'd1;
      end
   end

   // A fresh protocol error outranks a clear in the same cycle
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn)
         bus.ahb_err <= 1'b0;
      else if (ahb_strobe && (a_state != A_IDLE))
         bus.ahb_err <= 1'b1;
      else if (bus.ahb_err_clr)
         bus.ahb_err <= 1'b0;
   end

`ifdef WIFI_ARB_STATS_EN
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn)
         ahb_stall_cnt <= '0;
      else if (bus.ahb_err_clr)
         ahb_stall_cnt <= '0;
      else if (!bus.ahb_ready && (ahb_stall_cnt != 16'hFFFF))
         ahb_stall_cnt <= ahb_stall_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_wifi_mem_arbiter.sv
// Scoreboard bench for wifi_mem_arbiter with a behavioural single-port memory (read latency 1).
module tb_wifi_mem_arbiter;

   localparam int AW  = 10;
   localparam int DW  = 32;
   localparam int LAT = 1;
   localparam int MW  = 4;

   typedef struct {
      logic [DW-1:0] d;
      int            c;
   } phy_exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   logic [DW-1:0] mem [1024];
   logic [DW-1:0] ref_mem [1024];
   logic [DW-1:0] ahb_q [$];
   phy_exp_t      phy_q [$];
   logic          prev_ready;

   wifi_mem_arbiter_if #(.ADDR_SLIC(AW), .DATA_W(DW)) bus ();

`ifdef WIFI_ARB_STATS_EN
   logic [15:0] ahb_stall_cnt;
`endif

   wifi_mem_arbiter #(
      .ADDR_SLIC (AW),
      .DATA_W    (DW),
      .MEM_RD_LAT(LAT),
      .MAX_WAIT  (MW)
   ) dut (
      .HCLK   (clk),
      .HRESETn(rst_n),
      .bus    (bus)
`ifdef WIFI_ARB_STATS_EN
      ,
      .ahb_stall_cnt(ahb_stall_cnt)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
         else            bus.mem_rdata     <= mem[bus.mem_addr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) prev_ready <= bus.ahb_ready;

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.phy_rvalid) begin
            if (phy_q.size() == 0) begin
               chk("phy_rvalid_spurious", 32'(bus.phy_rvalid), 0);
            end else begin
               phy_exp_t e;
               e = phy_q.pop_front();
               chk("phy_rdata", bus.phy_rdata, e.d);
               chk("phy_rvalid_cycle", 32'(cyc), 32'(e.c));
            end
         end
         if (bus.ahb_ready && !prev_ready && (ahb_q.size() != 0))
            chk("ahb_rdata", bus.ahb_rdata, ahb_q.pop_front());
      end
   end

   task automatic ahb_access(input bit wr, input bit rd, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input int exp_low);
      int  n;
      bit  done;
      @(posedge clk); #1;
      bus.ahb_req_wr = wr;
      bus.ahb_req_rd = rd;
      bus.ahb_addr   = a;
      bus.ahb_wdata  = d;
      if (wr) ref_mem[a] = d;
      else    ahb_q.push_back(ref_mem[a]);
      @(posedge clk); #1;
      bus.ahb_req_wr = 1'b0;
      bus.ahb_req_rd = 1'b0;
      n    = 0;
      done = 1'b0;
      for (int k = 0; k < 20 && !done; k++) begin
         @(negedge clk);
         if (k == 0) begin
            chk("ahb_mem_en", 32'(bus.mem_en), 1);
            chk("ahb_mem_we", 32'(bus.mem_we), 32'(wr));
            chk("ahb_mem_addr", 32'(bus.mem_addr), 32'(a));
            if (wr) chk("ahb_mem_wdata", bus.mem_wdata, d);
         end
         if (bus.ahb_ready) done = 1'b1;
         else               n++;
      end
      chk("ahb_ready_low_cycles", 32'(n), 32'(exp_low));
   endtask

   task automatic phy_op(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output int gcyc);
      bit got;
      @(posedge clk); #1;
      bus.phy_req   = 1'b1;
      bus.phy_we    = we;
      bus.phy_addr  = a;
      bus.phy_wdata = d;
      got  = 1'b0;
      gcyc = -1;
      for (int k = 0; k < 30 && !got; k++) begin
         @(negedge clk);
         if (bus.phy_gnt) begin
            got  = 1'b1;
            gcyc = cyc;
            if (we) ref_mem[a] = d;
            else    phy_q.push_back('{d: ref_mem[a], c: cyc + LAT});
         end
      end
      chk("phy_gnt_seen", 32'(got), 1);
   endtask

   task automatic phy_idle();
      @(posedge clk); #1;
      bus.phy_req = 1'b0;
      bus.phy_we  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int gc;
      int first;
      int n;
      bit done;

      rst_n           = 1'b0;
      bus.ahb_req_wr  = 1'b0;
      bus.ahb_req_rd  = 1'b0;
      bus.ahb_addr    = '0;
      bus.ahb_wdata   = '0;
      bus.ahb_err_clr = 1'b0;
      bus.phy_req     = 1'b0;
      bus.phy_we      = 1'b0;
      bus.phy_addr    = '0;
      bus.phy_wdata   = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ahb_ready", 32'(bus.ahb_ready), 1);
      chk("rst_ahb_err", 32'(bus.ahb_err), 0);
      chk("rst_ahb_rdata", bus.ahb_rdata, 0);
      chk("rst_phy_rvalid", 32'(bus.phy_rvalid), 0);
      chk("rst_mem_en", 32'(bus.mem_en), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      ahb_access(1'b1, 1'b0, 10'h005, 32'hDEADBEEF, 1);
      ahb_access(1'b0, 1'b1, 10'h005, 32'h0, 2);

      for (int i = 0; i < 4; i++)
         phy_op(1'b1, AW'(i), 32'hA5A50000 + 32'(i) * 32'h01010101, gc);
      phy_idle();

      first = 0;
      for (int i = 0; i < 4; i++) begin
         phy_op(1'b0, AW'(i), 32'h0, gc);
         if (i == 0) first = gc;
         chk("phy_b2b_gnt_cycle", 32'(gc), 32'(first + i));
      end
      phy_idle();
      repeat (4) @(posedge clk);

      // PHY holds the memory; AHB write waits MAX_WAIT cycles then is forced in
      @(posedge clk); #1;
      bus.phy_req   = 1'b1;
      bus.phy_we    = 1'b1;
      bus.phy_addr  = 10'h020;
      bus.phy_wdata = 32'hCAFE0020;
      ref_mem[10'h020] = 32'hCAFE0020;
      @(posedge clk); #1;
      bus.ahb_req_wr = 1'b1;
      bus.ahb_addr   = 10'h006;
      bus.ahb_wdata  = 32'h12345678;
      ref_mem[10'h006] = 32'h12345678;
      @(negedge clk);
      chk("starve_phy_first", 32'(bus.phy_gnt), 1);
      @(posedge clk); #1;
      bus.ahb_req_wr = 1'b0;
      n    = 0;
      done = 1'b0;
      for (int k = 0; k < 20 && !done; k++) begin
         @(negedge clk);
         if (!bus.phy_gnt) done = 1'b1;
         else              n++;
      end
      chk("starve_phy_cycles", 32'(n), 32'(MW));
      chk("starve_ahb_mem_en", 32'(bus.mem_en), 1);
      chk("starve_ahb_mem_addr", 32'(bus.mem_addr), 32'h006);
      chk("starve_ahb_mem_wdata", bus.mem_wdata, 32'h12345678);
      @(negedge clk);
      chk("starve_phy_resume", 32'(bus.phy_gnt), 1);
      chk("starve_ahb_ready", 32'(bus.ahb_ready), 1);
      phy_idle();

      ahb_access(1'b0, 1'b1, 10'h006, 32'h0, 2);
      ahb_access(1'b0, 1'b1, 10'h020, 32'h0, 2);
      ahb_access(1'b1, 1'b1, 10'h00B, 32'h0B0B0B0B, 1);
      ahb_access(1'b0, 1'b1, 10'h00B, 32'h0, 2);

      // Strobe while pending is dropped and flags a sticky error
      @(posedge clk); #1;
      bus.ahb_req_wr = 1'b1;
      bus.ahb_addr   = 10'h008;
      bus.ahb_wdata  = 32'h0BADF00D;
      ref_mem[10'h008] = 32'h0BADF00D;
      @(posedge clk); #1;
      bus.ahb_req_wr = 1'b0;
      bus.ahb_req_rd = 1'b1;
      bus.ahb_addr   = 10'h009;
      @(posedge clk); #1;
      bus.ahb_req_rd = 1'b0;
      @(negedge clk);
      chk("err_set", 32'(bus.ahb_err), 1);
      repeat (3) @(negedge clk);
      chk("err_sticky", 32'(bus.ahb_err), 1);
      chk("err_no_stall", 32'(bus.ahb_ready), 1);
      @(posedge clk); #1;
      bus.ahb_err_clr = 1'b1;
      @(posedge clk); #1;
      bus.ahb_err_clr = 1'b0;
      @(negedge clk);
      chk("err_cleared", 32'(bus.ahb_err), 0);

      @(posedge clk); #1;
      bus.ahb_req_wr = 1'b1;
      bus.ahb_addr   = 10'h00A;
      bus.ahb_wdata  = 32'h0A0A0A0A;
      ref_mem[10'h00A] = 32'h0A0A0A0A;
      @(posedge clk); #1;
      bus.ahb_wdata   = 32'hFFFFFFFF;
      bus.ahb_err_clr = 1'b1;
      @(posedge clk); #1;
      bus.ahb_req_wr  = 1'b0;
      bus.ahb_err_clr = 1'b0;
      @(negedge clk);
      chk("err_beats_clr", 32'(bus.ahb_err), 1);
      @(posedge clk); #1;
      bus.ahb_err_clr = 1'b1;
      @(posedge clk); #1;
      bus.ahb_err_clr = 1'b0;
      @(negedge clk);
      chk("err_cleared2", 32'(bus.ahb_err), 0);
      ahb_access(1'b0, 1'b1, 10'h00A, 32'h0, 2);

      // Reset while the AHB read is waiting on its data
      @(posedge clk); #1;
      bus.ahb_req_rd = 1'b1;
      bus.ahb_addr   = 10'h005;
      @(posedge clk); #1;
      bus.ahb_req_rd = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rdwait_stalled", 32'(bus.ahb_ready), 0);
      #1 rst_n = 1'b0;
      #1 chk("rst_async_ready", 32'(bus.ahb_ready), 1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("post_rst_rdata", bus.ahb_rdata, 0);
         chk("post_rst_rvalid", 32'(bus.phy_rvalid), 0);
         chk("post_rst_ready", 32'(bus.ahb_ready), 1);
      end

      chk("ahb_q_drained", 32'(ahb_q.size()), 0);
      chk("phy_q_drained", 32'(phy_q.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wifi_mem_arbiter.md
Name: wifi_mem_arbiter

Overview:
- Shares the single-port WIFI sample memory between the AHB slave path and the PHY stream engine.
- AHB side takes memory strobes, address and write data from the WIFI address decoder; PHY side is a req/gnt streaming client.
- PHY has default priority; a starvation counter bounds AHB wait.
- Generates the stall (ready) for the AHB data phase and routes read data back to the correct requester.

Parameters:
- ADDR_SLIC, 10, memory word address width
- DATA_W, 32, memory data width
- MEM_RD_LAT, 1, memory read latency in cycles; legal 1..2
- MAX_WAIT, 4, cycles AHB may be denied before forced grant; legal 1..15

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  async active-low reset
- ahb_req_wr  in  1  one-cycle write strobe from decoder (wren_mem)
- ahb_req_rd  in  1  one-cycle read strobe from decoder (rden_mem)
- ahb_addr  in  ADDR_SLIC  memory address from decoder (addr_mem)
- ahb_wdata  in  DATA_W  write data
- ahb_rdata  out  DATA_W  registered read data
- ahb_ready  out  1  registered; 0 stalls AHB data phase
- ahb_err  out  1  sticky protocol-error flag
- ahb_err_clr  in  1  clears ahb_err
- phy_req  in  1  PHY access request; held until granted
- phy_we  in  1  PHY write (1) / read (0)
- phy_addr  in  ADDR_SLIC  PHY address
- phy_wdata  in  DATA_W  PHY write data
- phy_gnt  out  1  combinational; access issued this cycle
- phy_rvalid  out  1  PHY read data valid
- phy_rdata  out  DATA_W  PHY read data
- mem_en, mem_we  out  1  memory enable / write
- mem_addr  out  ADDR_SLIC  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_RD_LAT cycles after read issue

Behaviour:
- Clock/reset: one clock HCLK; reset asynchronous active-low HRESETn.
- Reset values: ahb_ready=1, ahb_err=0, ahb_rdata=0, phy_rvalid=0, pending cleared, wait_cnt=0, read tag pipeline cleared.
- Reset mid-operation: pending AHB access dropped; in-flight read tags discarded, so no rvalid/ready pulse after reset release.
- AHB FSM states: A_IDLE, A_PEND, A_RDWAIT.
- A_IDLE: strobe captures addr, wdata and we into pending; go to A_PEND; ahb_ready=0 from next cycle.
  - Both strobes asserted: write wins.
- A_PEND to A_RDWAIT on AHB read grant.
- A_PEND to A_IDLE on AHB write grant; ahb_ready=1 the cycle after grant.
- A_RDWAIT: on tag return, ahb_rdata<=mem_rdata, ahb_ready=1 next cycle, go to A_IDLE.
- Strobe while not A_IDLE: ignored; ahb_err set.
- ahb_err_clr clears ahb_err; a new error in the same cycle wins (err stays 1).
- Grant, evaluated each cycle:
  - AHB pending && (!phy_req || wait_cnt==MAX_WAIT): grant AHB.
  - Else phy_req: grant PHY (phy_gnt=1).
  - Else: no access, mem_en=0.
- wait_cnt: +1 each cycle AHB is in A_PEND and not granted; saturates at MAX_WAIT; cleared on AHB grant.
- Memory drive: mem_* driven combinationally from the granted source; at most one access per cycle.
- Read tag pipeline: a MEM_RD_LAT-deep shift register records the source of each read.
  - PHY tag: phy_rvalid=1 for one cycle, phy_rdata=mem_rdata.
  - AHB tag: handled as in A_RDWAIT.
- Back-to-back PHY reads: one per cycle, fully pipelined.
- Granted writes complete in the grant cycle; no response to PHY beyond phy_gnt.

Optional Feature:
- Macro: WIFI_ARB_STATS_EN.
- Defined: adds output ahb_stall_cnt[15:0].
  - Counts cycles with ahb_ready=0; saturates at 0xFFFF.
  - Cleared by reset and by ahb_err_clr.
- Undefined: port and counter absent; no other behaviour changes.

Test Plan:
- AHB write addr 0x05 data 0xDEADBEEF, PHY idle -> mem_en=mem_we=1, addr 0x05 the cycle after strobe; ahb_ready low 1 cycle, then 1.
- AHB read addr 0x05, MEM_RD_LAT=1 -> ahb_rdata=0xDEADBEEF; ahb_ready low exactly 2 cycles.
- PHY req held continuously, AHB write pending, MAX_WAIT=4 -> PHY granted 4 cycles, AHB granted on 5th (phy_gnt=0 that cycle), PHY resumes next cycle.
- PHY reads addr 0..3 back-to-back -> phy_gnt 4 consecutive cycles, phy_rvalid 4 consecutive cycles starting MEM_RD_LAT later, data in order.
- Second AHB strobe while in A_PEND -> ignored, ahb_err=1 and sticky; ahb_err_clr -> 0.
- HRESETn low during A_RDWAIT -> ahb_ready=1 immediately; no ahb_rdata update or phy_rvalid after release.
